vc_trace_line_serializer: RTL and testbench

//  Reader side of the line-trace buffer: accepts one packed trace string per handshake
//  and streams it out one byte per cycle over val/rdy, terminated by '\n'. Sits between
//  a design's line_trace storage and a byte sink (DPI console shim, debug UART, log FIFO).

---
 rtl/vc_trace_line_serializer.sv | 202 ++++++++++++++++++++
 tb/tb_vc_trace_line_serializer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_trace_line_serializer.sv
// Streams one packed trace buffer per handshake as bytes (top char first) followed by '\n'.
// Optional "NNNN: " line-number prefix is built when VC_TRACE_SER_CYCLE_PREFIX_EN is defined.
module vc_trace_line_serializer #(
   parameter int NCHARS = 512,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_val,
   output logic                in_rdy,
   input  logic [NCHARS*8-1:0] in_msg,
   output logic                out_val,
   input  logic                out_rdy,
   output logic [7:0]          out_msg,
   output logic                busy,
   output logic [CNT_W-1:0]    line_count
);

   localparam int IW = $clog2(NCHARS);
   localparam logic [IW-1:0] LAST = IW'(NCHARS - 1);

`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
   typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_BODY, S_NL} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_BODY, S_NL} state_t;
`endif

   state_t               state_q, state_d;
   logic [NCHARS*8-1:0]  stor_q, stor_d;
   logic [IW-1:0]        ptr_q, ptr_d, idx_q, idx_d, idx_c, ptr_m1;
   logic                 out_val_q, out_val_d, in_rdy_q, in_rdy_d;
   logic [7:0]           out_msg_q, out_msg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [31:0]          raw_idx;

`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
   logic [15:0] bcd_q, bcd_d;
   logic [2:0]  pos_q, pos_d;

   // Leading zeros of the 4-digit number print as spaces; the units digit always prints.
   function automatic logic [7:0] pfx_char(input logic [15:0] b, input logic [2:0] k);
      logic [7:0] c;
      case (k)
         3'd0:    c = (b[15:12] == 4'd0) ? 8'h20 : 8'h30 + {4'h0, b[15:12]};
         3'd1:    c = (b[15:8] == 8'd0)  ? 8'h20 : 8'h30 + {4'h0, b[11:8]};
         3'd2:    c = (b[15:4] == 12'd0) ? 8'h20 : 8'h30 + {4'h0, b[7:4]};
         3'd3:    c = 8'h30 + {4'h0, b[3:0]};
         3'd4:    c = 8'h3A;
         default: c = 8'h20;
      endcase
      return c;
   endfunction

   function automatic logic [15:0] bcd_inc(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      if (b[3:0] != 4'd9) r[3:0] = b[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (b[7:4] != 4'd9) r[7:4] = b[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (b[11:8] != 4'd9) r[11:8] = b[11:8] + 4'd1;
            else begin
               r[11:8]  = 4'd0;
               r[15:12] = (b[15:12] == 4'd9) ? 4'd0 : b[15:12] + 4'd1;
            end
         end
      end
      return r;
   endfunction
`endif

   // Chars 0..3 carry the index itself and are never emitted.
   assign raw_idx = in_msg[31:0];
   always_comb begin
      idx_c = raw_idx[IW-1:0];
      if (raw_idx < 32'd3)                    idx_c = IW'(3);
      else if (raw_idx >= 32'(NCHARS - 1))    idx_c = LAST;
   end

   assign ptr_m1 = ptr_q - 1'b1;

   always_comb begin
      state_d   = state_q;
      stor_d    = stor_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      out_val_d = out_val_q;
      out_msg_d = out_msg_q;
      cnt_d     = cnt_q;
`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
      bcd_d     = bcd_q;
      pos_d     = pos_q;
`endif
      case (state_q)
         S_IDLE: begin
            out_val_d = 1'b0;
            if (in_val && in_rdy_q) begin
               stor_d    = in_msg;
               idx_d     = idx_c;
               ptr_d     = LAST;
               out_val_d = 1'b1;
`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
               state_d   = S_PREFIX;
               pos_d     = 3'd0;
               out_msg_d = pfx_char(bcd_q, 3'd0);
`else
               if (LAST > idx_c) begin
                  state_d   = S_BODY;
                  out_msg_d = in_msg[NCHARS*8-1 -: 8];
               end else begin
                  state_d   = S_NL;
                  out_msg_d = 8'h0A;
               end
`endif
            end
         end
`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
         S_PREFIX: begin
            if (out_rdy) begin
               if (pos_q == 3'd5) begin
                  if (LAST > idx_q) begin
                     state_d   = S_BODY;
                     out_msg_d = stor_q[NCHARS*8-1 -: 8];
                  end else begin
                     state_d   = S_NL;
                     out_msg_d = 8'h0A;
                  end
               end else begin
                  pos_d     = pos_q + 3'd1;
                  out_msg_d = pfx_char(bcd_q, pos_q + 3'd1);
               end
            end
         end
`endif
         S_BODY: begin
            if (out_rdy) begin
               if (ptr_q == idx_q + 1'b1) begin
                  state_d   = S_NL;
                  out_msg_d = 8'h0A;
               end else begin
                  ptr_d     = ptr_m1;
                  out_msg_d = stor_q[{ptr_m1, 3'b000} +: 8];
               end
            end
         end
         S_NL: begin
            if (out_rdy) begin
               state_d   = S_IDLE;
               out_val_d = 1'b0;
               out_msg_d = 8'h00;
               cnt_d     = cnt_q + 1'b1;
`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
               bcd_d     = bcd_inc(bcd_q);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered ready rises one edge after reset release and after the '\n' handshake.
   assign in_rdy_d = (state_d == S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         stor_q    <= '0;
         ptr_q     <= '0;
         idx_q     <= '0;
         out_val_q <= 1'b0;
         out_msg_q <= 8'h00;
         in_rdy_q  <= 1'b0;
         cnt_q     <= '0;
`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
         bcd_q     <= '0;
         pos_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         stor_q    <= stor_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         out_val_q <= out_val_d;
         out_msg_q <= out_msg_d;
         in_rdy_q  <= in_rdy_d;
         cnt_q     <= cnt_d;
`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
         bcd_q     <= bcd_d;
         pos_q     <= pos_d;
`endif
      end
   end

   assign in_rdy     = in_rdy_q;
   assign out_val    = out_val_q;
   assign out_msg    = out_msg_q;
   assign busy       = (state_q != S_IDLE);
   assign line_count = cnt_q;

endmodule

// File: tb/tb_vc_trace_line_serializer.sv
// Bench for vc_trace_line_serializer: vector table, hand-timed corner sequences, random lines
// checked against a string-level reference model.
module tb_vc_trace_line_serializer;
   localparam int NCHARS = 512;
   localparam int CNT_W  = 16;
   localparam int BW     = NCHARS * 8;
`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
   localparam int P = 6;
`else
   localparam int P = 0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             in_val;
   logic             in_rdy;
   logic [BW-1:0]    in_msg;
   logic             out_val;
   logic             out_rdy;
   logic [7:0]       out_msg;
   logic             busy;
   logic [CNT_W-1:0] line_count;

   vc_trace_line_serializer #(.NCHARS(NCHARS), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
      .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .busy(busy),
      .line_count(line_count)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         lc_model = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   bit         rdy_auto = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_msg = 8'h00;

   typedef struct {
      logic [31:0] idx;
      logic [7:0]  fill;
      int          nbody;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Byte collector plus the stall-hold check (a stalled char must reappear unchanged).
   initial forever begin
      @(negedge clk);
      if (reset) prev_stall = 1'b0;
      else begin
         if (prev_stall) chk("hold", {23'b0, out_val, out_msg}, {23'b0, 1'b1, prev_msg});
         if (out_val && out_rdy) got_q.push_back(out_msg);
         prev_stall = out_val && !out_rdy;
         prev_msg   = out_msg;
      end
   end

   initial forever begin
      @(posedge clk);
      #2;
      if (rdy_auto) out_rdy = ($urandom_range(0, 3) != 0);
   end

   // Reference: optional "%4d: " line number, chars from the top down to the clamped index, '\n'.
   task automatic build_expect(input logic [BW-1:0] b);
      logic [31:0] raw;
      int e;
      raw = b[31:0];
      if (raw < 3) e = 3;
      else if (raw >= NCHARS - 1) e = NCHARS - 1;
      else e = int'(raw);
      exp_q.delete();
`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
      begin
         string s;
         s = $sformatf("%4d: ", lc_model % 10000);
         for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      end
`endif
      for (int c = NCHARS - 1; c > e; c--) exp_q.push_back(b[c*8 +: 8]);
      exp_q.push_back(8'h0A);
   endtask

   task automatic send_buf(input logic [BW-1:0] b);
      bit ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      in_msg = b;
      in_val = 1'b1;
      for (int i = 0; i < 5000 && !ok; i++) begin
         @(negedge clk);
         if (in_rdy) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      in_val = 1'b0;
      if (!ok) chk("accept timeout", 0, 1);
   endtask

   task automatic finish_line(input string nm, input int exp_len);
      int k;
      for (int i = 0; i < 6000 && got_q.size() < exp_q.size(); i++) @(negedge clk);
      repeat (2) @(negedge clk);
      lc_model++;
      k = 0;
      while (k < got_q.size() && k < exp_q.size() && got_q[k] === exp_q[k]) k++;
      if (k < got_q.size() && k < exp_q.size())
         chk($sformatf("%s byte%0d", nm, k), {24'b0, got_q[k]}, {24'b0, exp_q[k]});
      else
         chk({nm, " size"}, got_q.size(), exp_q.size());
      if (exp_len >= 0) chk({nm, " len"}, got_q.size(), exp_len);
      chk({nm, " line_count"}, {16'b0, line_count}, lc_model[15:0]);
      chk({nm, " idle"}, {30'b0, busy, in_rdy}, 32'h1);
   endtask

   task automatic run_line(input logic [BW-1:0] b, input string nm, input int exp_len);
      build_expect(b);
      got_q.delete();
      send_buf(b);
      finish_line(nm, exp_len);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      in_val = 1'b0;
      in_msg = '0;
      out_rdy = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset outputs", {21'b0, out_val, out_msg, busy, in_rdy}, 32'h0);
      chk("reset line_count", {16'b0, line_count}, 32'h0);
      reset = 1'b0;
      lc_model = 0;
      @(posedge clk);
      #1;
      chk("in_rdy after release", {31'b0, in_rdy}, 32'h1);
      got_q.delete();
   endtask

   logic [BW-1:0] b1, b;

   initial begin
      tbl[0] = '{32'd509,        8'h00, 2};
      tbl[1] = '{32'd511,        8'h00, 0};
      tbl[2] = '{32'd600,        8'h00, 0};
      tbl[3] = '{32'd0,          8'h41, 508};
      tbl[4] = '{32'd2,          8'h00, 508};
      tbl[5] = '{32'd3,          8'h00, 508};
      tbl[6] = '{32'd4,          8'h00, 507};
      tbl[7] = '{32'd510,        8'h00, 1};
      tbl[8] = '{32'hFFFF_FFFF,  8'h00, 0};
      tbl[9] = '{32'd100,        8'h00, 411};

      do_reset();

      // T1: exact cycle timing of a two-char line.
      b1 = '0;
      b1[511*8 +: 8] = 8'h61;
      b1[510*8 +: 8] = 8'h62;
      b1[31:0] = 32'd509;
      rdy_auto = 1'b0;
      out_rdy = 1'b1;
      in_msg = b1;
      in_val = 1'b1;
      build_expect(b1);
      got_q.delete();
      @(posedge clk);
      #1;
      in_val = 1'b0;
      for (int c = 1; c <= P + 4; c++) begin
         @(negedge clk);
         if (c == P + 1) chk("T1 a", {23'b0, out_val, out_msg}, {23'b0, 1'b1, 8'h61});
         if (c == P + 2) chk("T1 b", {23'b0, out_val, out_msg}, {23'b0, 1'b1, 8'h62});
         if (c == P + 3) chk("T1 nl", {23'b0, out_val, out_msg}, {23'b0, 1'b1, 8'h0A});
         if (c <= P + 3) chk($sformatf("T1 in_rdy low c%0d", c), {31'b0, in_rdy}, 32'h0);
         if (c == P + 4) begin
            chk("T1 in_rdy back", {30'b0, in_rdy, out_val}, 32'h2);
            chk("T1 line_count", {16'b0, line_count}, 32'h1);
         end
      end
      finish_line("T1", P + 3);

      // T3: stall while 'b' is presented.
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
      in_msg = b1;
      in_val = 1'b1;
      build_expect(b1);
      got_q.delete();
      @(posedge clk);
      #1;
      in_val = 1'b0;
      repeat (P + 1) @(posedge clk);
      #1;
      out_rdy = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk($sformatf("T3 stall%0d", s), {23'b0, out_val, out_msg}, {23'b0, 1'b1, 8'h62});
      end
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
      finish_line("T3", P + 3);

      // Vector table (clamp boundaries), random backpressure.
      rdy_auto = 1'b1;
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < NCHARS; c++)
            b[c*8 +: 8] = (tbl[r].fill != 8'h00) ? tbl[r].fill : 8'(97 + c % 26);
         b[31:0] = tbl[r].idx;
         run_line(b, $sformatf("tbl%0d", r), tbl[r].nbody + 1 + P);
      end

      // T5: reset in the middle of a long line.
      @(posedge clk);
      #1;
      rdy_auto = 1'b0;
      out_rdy = 1'b1;
      for (int w = 0; w < NCHARS / 4; w++) b[w*32 +: 32] = $urandom;
      b[31:0] = 32'd0;
      send_buf(b);
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("T5 async out_val/busy", {30'b0, out_val, busy}, 32'h0);
      chk("T5 async line_count", {16'b0, line_count}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      lc_model = 0;
      #1;
      chk("T5 in_rdy held low", {31'b0, in_rdy}, 32'h0);
      @(posedge clk);
      #1;
      chk("T5 in_rdy first edge", {31'b0, in_rdy}, 32'h1);
      run_line(b1, "T5 next", P + 3);

      // Random lines with random backpressure.
      rdy_auto = 1'b1;
      for (int n = 0; n < 30; n++) begin
         int r;
         logic [31:0] idx;
         r = $urandom_range(0, 9);
         if (r == 0)      idx = $urandom_range(0, 5);
         else if (r == 1) idx = $urandom;
         else             idx = $urandom_range(380, 620);
         for (int w = 0; w < NCHARS / 4; w++) b[w*32 +: 32] = $urandom;
         b[31:0] = idx;
         run_line(b, $sformatf("rnd%0d", n), -1);
      end

`ifdef VC_TRACE_SER_CYCLE_PREFIX_EN
      // Push the line number to the 9999 -> 0 wrap with back-to-back empty lines.
      begin
         int target;
         bit done;
         target = ((lc_model / 10000) + 1) * 10000;
         @(posedge clk);
         #1;
         rdy_auto = 1'b0;
         out_rdy = 1'b1;
         b = '0;
         b[31:0] = 32'd600;
         in_msg = b;
         in_val = 1'b1;
         done = 1'b0;
         for (int i = 0; i < 95000 && !done; i++) begin
            @(negedge clk);
            if (line_count == CNT_W'(target - 1) && busy) done = 1'b1;
         end
         in_val = 1'b0;
         for (int i = 0; i < 50 && line_count != CNT_W'(target); i++) @(negedge clk);
         chk("wrap line_count", {16'b0, line_count}, 32'(target % 65536));
         lc_model = target;
         @(negedge clk);
         run_line(b1, "T6 wrap", P + 3);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
